// File: rtl/fixed_divide.sv
// Sequential signed fixed-point divider: q = a * 2^WIDTH / b, truncated toward zero and
// saturated to the signed WIDTH-bit range. Restoring division, one quotient bit per clock.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, accepted on a rising edge where ready=1
//   a, b       signed dividend / divisor, sampled on accept
//   ready      high only while idle
//   out_valid  one-cycle pulse when a new result is loaded
//   q          signed quotient, held until the next result
//   div_zero   result came from b=0 (held with q)
//   saturated  result was clamped (held with q)
module fixed_divide #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic             div_zero,
  output logic             saturated
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]  CntInit = CntW'(WIDTH);
  localparam logic [WIDTH-1:0] MaxPos  = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic              sign_q, sign_d;
  logic [WIDTH:0]    absb_q, absb_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic [WIDTH-2:0]  quo_q, quo_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fast_q, fast_d;
  logic              fdz_q, fdz_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              dz_q, dz_d;
  logic              sat_q, sat_d;

  // Operand magnitudes as WIDTH+1 bits so the most negative value has a representable magnitude.
  logic [WIDTH:0] a_ext, b_ext, a_abs, b_abs;
  logic           b_zero;

  always_comb begin
    a_ext  = {a[WIDTH-1], a};
    b_ext  = {b[WIDTH-1], b};
    a_abs  = a[WIDTH-1] ? -a_ext : a_ext;
    b_abs  = b[WIDTH-1] ? -b_ext : b_ext;
    b_zero = (b == '0);
  end

  // One restoring step; the shifted remainder needs WIDTH+2 bits.
  logic [WIDTH+1:0] rem_sh;
  logic             step_ge;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] mag;

  always_comb begin
    rem_sh  = {rem_q, 1'b0};
    step_ge = (rem_sh >= {1'b0, absb_q});
    rem_nx  = step_ge ? (WIDTH + 1)'(rem_sh - {1'b0, absb_q}) : rem_sh[WIDTH:0];
    mag     = {quo_q, step_ge};
  end

  // Apply the sign to the final magnitude; only -2^(WIDTH-1) is reachable without clamping
  // on the negative side when mag equals 2^(WIDTH-1).
  logic [WIDTH-1:0] res_q;
  logic             res_sat;

  always_comb begin
    res_q   = mag;
    res_sat = 1'b0;
    if (sign_q) begin
      if (mag > MinNeg) begin
        res_q   = MinNeg;
        res_sat = 1'b1;
      end else begin
        res_q = -mag;
      end
    end else if (mag > MaxPos) begin
      res_q   = MaxPos;
      res_sat = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    absb_d  = absb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    fast_d  = fast_q;
    fdz_d   = fdz_q;
    q_d     = q_q;
    dz_d    = dz_q;
    sat_d   = sat_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          // For b=0 the clamp direction follows the dividend alone.
          sign_d  = b_zero ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);
          absb_d  = b_abs;
          rem_d   = a_abs;
          quo_d   = '0;
          cnt_d   = CntInit;
          fast_d  = b_zero || (a_abs >= b_abs);
          fdz_d   = b_zero;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (fast_q) begin
          // Fast path spends a single cycle here so DONE lands one edge after accept.
          q_d     = sign_q ? MinNeg : MaxPos;
          sat_d   = 1'b1;
          dz_d    = fdz_q;
          state_d = StDone;
        end else begin
          rem_d = rem_nx;
          quo_d = mag[WIDTH-2:0];
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            q_d     = res_q;
            sat_d   = res_sat;
            dz_d    = 1'b0;
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      absb_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      fast_q  <= 1'b0;
      fdz_q   <= 1'b0;
      q_q     <= '0;
      dz_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      absb_q  <= absb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      fast_q  <= fast_d;
      fdz_q   <= fdz_d;
      q_q     <= q_d;
      dz_q    <= dz_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    ready     = (state_q == StIdle);
    out_valid = (state_q == StDone);
    q         = q_q;
    div_zero  = dz_q;
    saturated = sat_q;
  end

endmodule

// File: tb/tb_fixed_divide.sv
module tb_fixed_divide;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready, out_valid, div_zero, saturated;
  logic [15:0] q;

  fixed_divide #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .out_valid (out_valid),
    .q         (q),
    .div_zero  (div_zero),
    .saturated (saturated)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int a;
    int b;
    int q;
    bit dz;
    bit sat;
    int edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   hold_q = 0;
  bit   hold_dz = 1'b0;
  bit   hold_sat = 1'b0;

  // Reference: exact quotient truncated toward zero, then clamped to 16-bit signed.
  function automatic exp_t model(int av, int bv);
    exp_t   e;
    longint t;
    e.a = av; e.b = bv; e.dz = 1'b0; e.sat = 1'b0; e.edge_n = 0; e.q = 0;
    if (bv == 0) begin
      e.dz  = 1'b1;
      e.sat = 1'b1;
      e.q   = (av >= 0) ? 32767 : -32768;
    end else begin
      t = (longint'(av) * 65536) / longint'(bv);
      if (t > 32767) begin
        e.q = 32767; e.sat = 1'b1;
      end else if (t < -32768) begin
        e.q = -32768; e.sat = 1'b1;
      end else begin
        e.q = int'(t);
      end
    end
    return e;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: every cycle out of reset, either a new result or the held one.
  exp_t   mon_e;
  longint mon_prod;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected out_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("latency edge", cyc, mon_e.edge_n);
          check("q", int'($signed(q)), mon_e.q);
          check("div_zero", int'(div_zero), int'(mon_e.dz));
          check("saturated", int'(saturated), int'(mon_e.sat));
          if (!mon_e.sat && !mon_e.dz) begin
            mon_prod = (longint'($signed(q)) * longint'(mon_e.b)) >>> 16;
            check("multiply inverse within 1 LSB",
                  int'((mon_prod - longint'(mon_e.a)) inside {-1, 0, 1}), 1);
          end
          hold_q   = mon_e.q;
          hold_dz  = mon_e.dz;
          hold_sat = mon_e.sat;
        end
      end else begin
        check("q held", int'($signed(q)), hold_q);
        check("div_zero held", int'(div_zero), int'(hold_dz));
        check("saturated held", int'(saturated), int'(hold_sat));
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the accept edge.
  task automatic issue(int av, int bv);
    exp_t e;
    int   waited = 0;
    bit   fast;
    while (!ready && waited < 100) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!ready) begin
      check("ready timeout", 0, 1);
      return;
    end
    a     = av[15:0];
    b     = bv[15:0];
    start = 1'b1;
    fast  = (bv == 0) || (iabs(av) >= iabs(bv));
    e     = model(av, bv);
    e.edge_n = cyc + 1 + (fast ? 1 : 16);
    exp_q.push_back(e);
    @(posedge clk); #2;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((exp_q.size() != 0 || !ready) && waited < 60) begin
      @(posedge clk); #2;
      waited++;
    end
    if (exp_q.size() != 0) check("result timeout", exp_q.size(), 0);
  endtask

  int dir_a[11] = '{1000, -1000, 16384, 8192, 5, -5, 0, -32768, -32768, 32767, -1};
  int dir_b[11] = '{3000, 3000, -32768, 16384, 5, 0, 0, 1, -32768, -32768, 32767};

  initial begin
    exp_t m;
    int   av, bv, mg;

    // Pin the model against hand-computed values.
    m = model(1000, 3000);   check("model 1000/3000", m.q, 21845);
    m = model(-1000, 3000);  check("model -1000/3000", m.q, -21845);
    m = model(16384, -32768);
    check("model 16384/-32768 q", m.q, -32768);
    check("model 16384/-32768 sat", int'(m.sat), 0);
    m = model(8192, 16384);  check("model 8192/16384 sat", int'(m.sat), 1);
    m = model(-5, 0);        check("model -5/0 q", m.q, -32768);

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("reset ready", int'(ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset q", int'(q), 0);
    check("reset div_zero", int'(div_zero), 0);
    check("reset saturated", int'(saturated), 0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 11; i++) begin
      issue(dir_a[i], dir_b[i]);
      wait_idle();
    end

    // Second start mid-division must be ignored.
    issue(1000, 3000);
    repeat (4) @(posedge clk);
    #2;
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();

    // Reset in the middle of CALC discards the division.
    issue(12345, 23456);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    hold_q = 0; hold_dz = 1'b0; hold_sat = 1'b0;
    #1;
    check("midcalc reset ready", int'(ready), 1);
    check("midcalc reset out_valid", int'(out_valid), 0);
    check("midcalc reset q", int'(q), 0);
    check("midcalc reset saturated", int'(saturated), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #2;

    // Random sweep, mostly |a| < |b|, plus some unconstrained pairs.
    for (int i = 0; i < 2500; i++) begin
      bv = int'($signed(16'($urandom)));
      if (bv == 0) bv = 1;
      mg = iabs(bv);
      av = int'($urandom_range(mg - 1, 0));
      if ($urandom_range(1, 0) == 1) av = -av;
      issue(av, bv);
    end
    for (int i = 0; i < 300; i++) begin
      av = int'($signed(16'($urandom)));
      bv = ($urandom_range(15, 0) == 0) ? 0 : int'($signed(16'($urandom)));
      issue(av, bv);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
